// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// The REGFILE_BYPASS_EN macro is consumed by reg_bank; nothing here depends on it.
package regfile_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NREGS = 8;
  localparam int DEF_WIDTH = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester/read bus between datapath producers and the register-file write arbiter.
// Per-requester fields are packed arrays; slice i belongs to requester i.
interface regfile_write_arbiter_if #(
  parameter int NREQ  = regfile_arb_pkg::DEF_NREQ,
  parameter int NREGS = regfile_arb_pkg::DEF_NREGS,
  parameter int WIDTH = regfile_arb_pkg::DEF_WIDTH
);
  import regfile_arb_pkg::*;

  localparam int AW = clog2_min1(NREGS);
  localparam int OW = clog2_min1(NREQ);

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_last;
  logic [NREQ-1:0][AW-1:0]    req_addr;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic [NREQ-1:0]            gnt;
  logic                       busy;
  logic [OW-1:0]              owner;
  logic [AW-1:0]              rd_addr;
  logic [WIDTH-1:0]           rd_data;

  modport master (
    output req, req_last, req_addr, req_data, rd_addr,
    input  gnt, busy, owner, rd_data
  );

  modport slave (
    input  req, req_last, req_addr, req_data, rd_addr,
    output gnt, busy, owner, rd_data
  );

endinterface

// File: rtl/regfile_write_arbiter_reg_bank.sv
// NREGS x WIDTH storage: one write port, synchronous clear, combinational read.
// With REGFILE_BYPASS_EN defined, a same-cycle write to rd_addr is forwarded to rd_data.
module reg_bank
  import regfile_arb_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = clog2_min1(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]            stored;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset)
        regs[i] <= '0;
      else if (wr_en && (wr_addr == AW'(i)))
        regs[i] <= wr_data;
    end
  end

  assign stored = regs[rd_addr];

`ifdef REGFILE_BYPASS_EN
  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : stored;
`else
  assign rd_data = stored;
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter with burst ownership in front of a shared register bank.
// Optional same-cycle read forwarding via REGFILE_BYPASS_EN (implemented in reg_bank).
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int AW = clog2_min1(NREGS);
  localparam int OW = clog2_min1(NREQ);

  arb_state_e       state_q, state_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    winner;
  logic             found;
  logic [NREQ-1:0]  gnt;
  logic [OW-1:0]    wr_sel;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
    if (int'(i) == NREQ - 1)
      return '0;
    else
      return i + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = rr_ptr_q;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt      = '0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          gnt[winner] = 1'b1;
          owner_d     = winner;
          if (bus.req_last[winner])
            rr_ptr_d = wrap_inc(winner);
          else
            state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        // A stalled owner keeps the bank; nobody else can get in.
        if (bus.req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          if (bus.req_last[owner_q]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (reset)
      gnt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Grant is one-hot, so the write source is simply the granted index.
  assign wr_sel  = (state_q == ARB_IDLE) ? winner : owner_q;
  assign wr_en   = |gnt;
  assign wr_addr = bus.req_addr[wr_sel];
  assign wr_data = bus.req_data[wr_sel];

  reg_bank #(
    .NREGS (NREGS),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.gnt   = gnt;
  assign bus.busy  = (state_q == ARB_OWN);
  assign bus.owner = owner_q;

endmodule
